// File: rtl/timer_pkg.sv
// Shared types and constants for the programmable down-timer.
package timer_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } timer_state_t;

    localparam logic MODE_ONESHOT = 1'b0;
    localparam logic MODE_RELOAD  = 1'b1;

endpackage

// File: rtl/tick_gen.sv
// Prescaler: emits a one-cycle tick every PRESCALE enabled cycles.
module tick_gen #(
    parameter int PRESCALE = 100000
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [W-1:0] LAST = W'(PRESCALE - 1);

    logic [W-1:0] cnt_reg;

    // With PRESCALE=1 the terminal value is 0, so the counter never leaves 0 and tick follows en.
    assign tick = en && (cnt_reg == LAST);

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            cnt_reg <= '0;
        end else if (en) begin
            if (cnt_reg == LAST) begin
                cnt_reg <= '0;
            end else begin
                cnt_reg <= cnt_reg + W'(1);
            end
        end
    end

endmodule

// File: rtl/prog_down_timer.sv
// Programmable down-timer with one-shot/auto-reload modes, pause, abort and done pulse.
module prog_down_timer
    import timer_pkg::*;
#(
    parameter int WIDTH    = 16,
    parameter int PRESCALE = 100000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] load_val,
    input  logic             mode,
    input  logic             pause,
    input  logic             abort,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             done
);

    timer_state_t     state_reg,  state_next;
    logic [WIDTH-1:0] count_reg,  count_next;
    logic [WIDTH-1:0] reload_reg, reload_next;
    logic             mode_reg,   mode_next;
    logic             done_reg,   done_next;
    logic             tick;
    logic             tick_en;

    // Prescaler only advances in cycles where nothing outranks the tick.
    assign tick_en = (state_reg != IDLE) && !pause && !abort && !start;

    tick_gen #(
        .PRESCALE(PRESCALE)
    ) u_tick_gen (
        .clk  (clk),
        .reset(reset),
        .en   (tick_en),
        .clr  (start || abort),
        .tick (tick)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg  <= IDLE;
            count_reg  <= '0;
            reload_reg <= '0;
            mode_reg   <= MODE_ONESHOT;
            done_reg   <= 1'b0;
        end else begin
            state_reg  <= state_next;
            count_reg  <= count_next;
            reload_reg <= reload_next;
            mode_reg   <= mode_next;
            done_reg   <= done_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        count_next  = count_reg;
        reload_next = reload_reg;
        mode_next   = mode_reg;
        done_next   = 1'b0;
        if (abort) begin
            state_next = IDLE;
            count_next = '0;
        end else if (start) begin
            reload_next = load_val;
            mode_next   = mode;
            count_next  = load_val;
            // A zero start value terminates immediately, even in auto-reload.
            if (load_val == '0) begin
                state_next = IDLE;
                done_next  = 1'b1;
            end else begin
                state_next = RUN;
            end
        end else if (state_reg != IDLE) begin
            if (pause) begin
                state_next = PAUSE;
            end else begin
                state_next = RUN;
                if (tick) begin
                    if (count_reg > WIDTH'(1)) begin
                        count_next = count_reg - WIDTH'(1);
                    end else begin
                        done_next = 1'b1;
                        if (mode_reg == MODE_RELOAD) begin
                            count_next = reload_reg;
                        end else begin
                            count_next = '0;
                            state_next = IDLE;
                        end
                    end
                end
            end
        end
    end

    assign count = count_reg;
    assign busy  = (state_reg != IDLE);
    assign done  = done_reg;

endmodule
